// File: rtl/mmio_interrupt_controller.sv
// Memory-mapped interrupt controller: latches rising edges of device request lines,
// picks the lowest-index pending unmasked source, and runs a REQ/ack/EOI handshake.
module mmio_interrupt_controller #(
  parameter int unsigned NUM_SRC      = 8,
  parameter logic [31:0] ADDRESS_BASE = 32'hF0000800
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               writeEn,
  input  logic [31:0]        addr,
  inout  wire logic [31:0]   bus,
  input  logic [NUM_SRC-1:0] src,
  input  logic               intAck,
  output logic               intReq,
  output logic [4:0]         intId
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;

  logic [1:0]         state;
  logic [NUM_SRC-1:0] pend, mask, src_prev, ovr;
  logic               gie;

  logic [NUM_SRC-1:0] rise, cand, sel, ack_clr, w1c, wdata;
  logic [4:0]         winner;
  logic               eligible, cur_ok;
  logic               hit_pend, hit_mask, hit_ctrl, hit_cause;
  logic [31:0]        rdata;

  assign hit_pend  = (addr == ADDRESS_BASE);
  assign hit_mask  = (addr == ADDRESS_BASE + 32'd4);
  assign hit_ctrl  = (addr == ADDRESS_BASE + 32'd8);
  assign hit_cause = (addr == ADDRESS_BASE + 32'd12);
  assign wdata     = bus[NUM_SRC-1:0];

  always_comb begin
    rise   = src & ~src_prev;
    cand   = pend & mask;
    winner = '0;
    // Descending scan so the lowest set index is the last (winning) assignment.
    for (int unsigned i = NUM_SRC; i > 0; i--) begin
      if (cand[i-1]) winner = 5'(i - 1);
    end
    sel = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      sel[i] = (5'(i) == intId);
    end
    eligible = gie & (|cand);
    cur_ok   = gie & (|(cand & sel));
    ack_clr  = (state == REQ && intAck) ? sel : '0;
    w1c      = (writeEn && hit_pend) ? wdata : '0;
  end

  always_comb begin
    rdata = '0;
    if (hit_pend)  rdata = 32'(pend);
    if (hit_mask)  rdata = 32'(mask);
    if (hit_ctrl)  rdata = {29'd0, |ovr, state != IDLE, gie};
    if (hit_cause) rdata = {state == SERVICE, 26'd0, intId};
  end

  assign bus = (!writeEn && (hit_pend || hit_mask || hit_ctrl || hit_cause)) ? rdata : 'z;

  always_ff @(negedge clk) begin
    if (reset) begin
      pend     <= '0;
      mask     <= '0;
      src_prev <= '0;
      ovr      <= '0;
      gie      <= 1'b0;
      state    <= IDLE;
      intReq   <= 1'b0;
      intId    <= '0;
    end else begin
      src_prev <= src;
      // A fresh edge always wins over software clear and acknowledge clear.
      pend <= (pend & ~w1c & ~ack_clr) | rise;
      ovr  <= ((writeEn && hit_ctrl && bus[2]) ? '0 : ovr) | (rise & pend & ~ack_clr);
      if (writeEn && hit_mask) mask <= wdata;
      if (writeEn && hit_ctrl) gie  <= bus[0];
      case (state)
        IDLE: begin
          if (eligible) begin
            intId  <= winner;
            intReq <= 1'b1;
            state  <= REQ;
          end
        end
        REQ: begin
          if (intAck) begin
            intReq <= 1'b0;
            state  <= SERVICE;
          end else if (!cur_ok) begin
            intReq <= 1'b0;
            state  <= IDLE;
          end
        end
        SERVICE: begin
          intReq <= 1'b0;
          if (writeEn && hit_cause) state <= IDLE;
        end
        default: begin
          intReq <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_interrupt_controller.sv
// Scoreboard bench for mmio_interrupt_controller: stimulus queues expected
// observations, a monitor pops and compares them each checked cycle.
module tb_mmio_interrupt_controller;

  localparam logic [31:0] BASE    = 32'hF0000800;
  localparam logic [31:0] A_PEND  = BASE;
  localparam logic [31:0] A_MASK  = BASE + 32'd4;
  localparam logic [31:0] A_CTRL  = BASE + 32'd8;
  localparam logic [31:0] A_CAUSE = BASE + 32'd12;

  logic        clk;
  logic        reset;
  logic        writeEn;
  logic [31:0] addr;
  wire  [31:0] bus;
  logic [7:0]  src;
  logic        intAck;
  logic        intReq;
  logic [4:0]  intId;

  logic        tb_oe;
  logic [31:0] tb_data;
  logic        obs_valid;

  assign bus = tb_oe ? tb_data : 'z;

  mmio_interrupt_controller #(.NUM_SRC(8), .ADDRESS_BASE(BASE)) dut (
    .clk(clk), .reset(reset), .writeEn(writeEn), .addr(addr), .bus(bus),
    .src(src), .intAck(intAck), .intReq(intReq), .intId(intId)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          kind;  // 0 = bus read data, 1 = intReq, 2 = intId
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // State updates on negedge (posedge + 5); sampling at posedge + 4 sees the
  // result of the previous negedge while inputs set at posedge + 1 are applied.
  initial begin
    chk_t        c;
    logic [31:0] act;
    forever begin
      @(posedge clk);
      #4;
      if (obs_valid) begin
        while (sb.size() > 0) begin
          c = sb.pop_front();
          case (c.kind)
            0:       act = bus;
            1:       act = {31'd0, intReq};
            default: act = {27'd0, intId};
          endcase
          vectors++;
          if (act !== c.exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    writeEn   = 1'b0;
    tb_oe     = 1'b0;
    intAck    = 1'b0;
    obs_valid = 1'b0;
    addr      = 32'h0;
  endtask

  task automatic set_wr(input logic [31:0] a, input logic [31:0] d);
    addr    = a;
    writeEn = 1'b1;
    tb_oe   = 1'b1;
    tb_data = d;
  endtask

  task automatic set_rd(input logic [31:0] a, input logic [31:0] e, input string n);
    chk_t c;
    addr    = a;
    writeEn = 1'b0;
    tb_oe   = 1'b0;
    c.kind = 0; c.exp = e; c.name = n;
    sb.push_back(c);
    obs_valid = 1'b1;
  endtask

  task automatic exp_irq(input logic req, input logic [4:0] id, input string n);
    chk_t c;
    c.kind = 1; c.exp = {31'd0, req}; c.name = {n, "_req"};
    sb.push_back(c);
    c.kind = 2; c.exp = {27'd0, id};  c.name = {n, "_id"};
    sb.push_back(c);
    obs_valid = 1'b1;
  endtask

  task automatic exp_req(input logic req, input string n);
    chk_t c;
    c.kind = 1; c.exp = {31'd0, req}; c.name = n;
    sb.push_back(c);
    obs_valid = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; writeEn = 1'b0; addr = '0; src = '0; intAck = 1'b0;
    tb_oe = 1'b0; tb_data = '0; obs_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    tick(); set_rd(A_CTRL, 32'h0, "rst_ctrl"); exp_irq(1'b0, 5'd0, "rst_irq");
    tick(); set_rd(A_PEND, 32'h0, "rst_pend");
    tick(); set_rd(A_CAUSE, 32'h0, "rst_cause");
    tick(); set_rd(A_MASK, 32'h0, "rst_mask");

    // Single source, latency and handshake
    tick(); set_wr(A_MASK, 32'h05);
    tick(); set_wr(A_CTRL, 32'h1);
    tick(); src = 8'h04;
    tick(); src = 8'h00; set_rd(A_PEND, 32'h04, "s2_pend"); exp_req(1'b0, "s2_lat1");
    tick(); exp_irq(1'b1, 5'd2, "s2_req"); intAck = 1'b1;
    tick(); set_rd(A_PEND, 32'h0, "s2_pend_ack"); exp_req(1'b0, "s2_drop");
    tick(); set_rd(A_CAUSE, 32'h80000002, "s2_cause");
    tick(); set_rd(A_CTRL, 32'h3, "s2_ctrl_busy");
    tick(); set_wr(A_CAUSE, 32'h0);
    tick(); set_rd(A_CTRL, 32'h1, "s2_ctrl_eoi"); exp_req(1'b0, "s2_idle");

    // Priority and back-to-back re-issue after EOI
    tick(); set_wr(A_MASK, 32'hFF);
    tick(); src = 8'h0A;
    tick(); src = 8'h00;
    tick(); exp_irq(1'b1, 5'd1, "pri_first"); intAck = 1'b1;
    tick(); set_rd(A_PEND, 32'h08, "pri_pend"); exp_req(1'b0, "pri_svc");
    tick(); set_wr(A_CAUSE, 32'h0);
    tick(); exp_req(1'b0, "pri_gap");
    tick(); exp_irq(1'b1, 5'd3, "pri_second"); intAck = 1'b1;
    tick(); set_wr(A_CAUSE, 32'h0);
    tick(); set_rd(A_PEND, 32'h0, "pri_pend_done");
    tick(); set_rd(A_CTRL, 32'h1, "pri_ctrl_done");

    // Masking the active source withdraws the request
    tick(); src = 8'h01;
    tick();
    tick(); exp_irq(1'b1, 5'd0, "mask_req"); set_wr(A_MASK, 32'h0);
    tick(); exp_req(1'b1, "mask_hold");
    tick(); set_rd(A_CTRL, 32'h1, "mask_ctrl"); exp_req(1'b0, "mask_drop");
    tick(); set_rd(A_PEND, 32'h01, "mask_pend");

    // Overrun
    tick(); src = 8'h10;
    tick(); src = 8'h00;
    tick(); src = 8'h10;
    tick(); set_rd(A_CTRL, 32'h5, "ovr_set");
    tick(); set_wr(A_CTRL, 32'h5);
    tick(); set_rd(A_CTRL, 32'h1, "ovr_clr");
    tick(); set_rd(A_PEND, 32'h11, "ovr_pend");

    // Edge coinciding with write-1-to-clear: set wins
    tick(); src = 8'h00;
    tick(); src = 8'h10; set_wr(A_PEND, 32'h10);
    tick(); set_rd(A_PEND, 32'h11, "w1c_setwins");

    // Edge coinciding with acknowledge clear: set wins, no overrun
    tick(); set_wr(A_PEND, 32'hFFFFFFFF); src = 8'h00;
    tick(); set_wr(A_CTRL, 32'h5);
    tick(); set_wr(A_MASK, 32'h80);
    tick(); src = 8'h80;
    tick(); src = 8'h00;
    tick(); exp_irq(1'b1, 5'd7, "ack_req"); intAck = 1'b1; src = 8'h80;
    tick(); set_rd(A_PEND, 32'h80, "ack_setwins"); exp_req(1'b0, "ack_drop");
    tick(); set_rd(A_CTRL, 32'h3, "ack_noovr");
    tick(); set_wr(A_CAUSE, 32'h0);
    tick(); exp_req(1'b0, "reissue_gap");
    tick(); exp_irq(1'b1, 5'd7, "reissue_req"); intAck = 1'b1;
    tick(); set_rd(A_CAUSE, 32'h80000007, "svc_cause");

    // Reset while in service
    tick(); reset = 1'b1; src = 8'h00;
    tick(); reset = 1'b0;
    tick(); set_rd(A_CAUSE, 32'h0, "rst2_cause"); exp_irq(1'b0, 5'd0, "rst2_irq");
    tick(); set_rd(A_MASK, 32'h0, "rst2_mask");
    tick(); intAck = 1'b1; src = 8'h01;
    tick(); src = 8'h00;
    tick(); set_rd(A_CTRL, 32'h0, "rst2_ctrl"); exp_req(1'b0, "rst2_noreq1");
    tick(); set_rd(A_PEND, 32'h01, "rst2_pend"); exp_req(1'b0, "rst2_noreq2");

    tick();
    tick();
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mmio_interrupt_controller.md
Name: mmio_interrupt_controller

Overview:
- Memory-mapped interrupt controller for the processor's I/O space.
- Collects level "ready & ie" request lines from up to NUM_SRC mapped input devices and latches their rising edges as pending bits.
- Selects one pending, unmasked source by fixed priority and raises a single interrupt request to the processor.
- Tracks the acknowledge and end-of-interrupt handshake so that only one interrupt is in service at a time.

Parameters:
- NUM_SRC, 8, number of request inputs (1..32).
- ADDRESS_BASE, 32'hF0000800, address of PEND. MASK = +4, CTRL = +8, CAUSE = +12.

Ports:
- clk  input  1  system clock. All state updates on negedge clk.
- reset  input  1  synchronous, active-high reset, sampled on negedge clk.
- writeEn  input  1  bus write strobe. 1 = processor writes, 0 = processor reads.
- addr  input  32  bus address.
- bus  inout  32  shared data bus. Driven only on a read of an own register, else 32'bz.
- src  input  NUM_SRC  request lines from devices, level-sensitive.
- intAck  input  1  processor accepts the interrupt, 1-cycle pulse.
- intReq  output  1  interrupt request to processor, registered.
- intId  output  5  index of the source being requested or serviced, registered.

Behaviour:
- Reset (reset=1 at negedge): pend, mask, srcPrev, ovr and gie = 0; state = IDLE; intReq = 0; intId = 0. Reset dominates every other event, including mid-REQ and mid-SERVICE.
- Edge detect: srcPrev <= src each negedge. A 0→1 change on src[i] sets pend[i].
- Overrun: if pend[i] is already 1 when a new edge on src[i] arrives, set sticky ovr[i].
- Register map, reads (combinational drive when addr matches and writeEn = 0):
  - PEND: {0, pend}.
  - MASK: {0, mask}.
  - CTRL: bit0 = gie, bit1 = (state != IDLE), bit2 = |ovr, others 0.
  - CAUSE: bit31 = (state == SERVICE), bits[4:0] = intId, others 0.
- Register map, writes (at negedge when addr matches and writeEn = 1):
  - PEND: write-1-to-clear.
  - MASK: load bits [NUM_SRC-1:0].
  - CTRL: gie <= bus[0]; bus[2] = 1 clears all ovr.
  - CAUSE: any value = EOI.
- Unused upper bits of bus read as 0. Addresses outside the 4 registers: no drive, no effect.
- Priority: lowest index among (pend & mask) wins. "Eligible" means gie & |(pend & mask).
- FSM:
  - IDLE: if eligible, latch intId = winner and go to REQ.
  - REQ:
    - intReq = 1.
    - If intAck: clear pend[intId], go to SERVICE, drop intReq.
    - Else if pend[intId] & mask[intId] & gie has become 0 (software clear, mask or disable): go to IDLE, drop intReq.
    - intId does not change in REQ even if a higher-priority source becomes pending (no preemption).
  - SERVICE: intReq = 0; wait for EOI. On EOI go to IDLE. An EOI written outside SERVICE is ignored.
- intReq and intId are registered. intReq is 1 exactly in the cycles after entering REQ until the negedge that leaves REQ.
- Latency: src edge sampled at negedge N → pend visible from N. IDLE→REQ at N+1 → intReq = 1 after N+1. Minimum edge-to-request = 2 negedges.
- Simultaneous events on the same bit:
  - new edge and W1C: set wins.
  - new edge and ack-clear: set wins; pend stays 1 and ovr is not set.
  - EOI and a new eligible source: go to IDLE; the request is re-issued one cycle later.
- intAck while not in REQ is ignored.

Test Plan:
- Reset, then read CTRL, PEND and CAUSE → all 0, intReq = 0, bus = z when not addressed.
- MASK = 0x05, gie = 1. Pulse src[2] → PEND = 0x04. intReq = 1 two negedges after the edge, intId = 2. Ack → PEND = 0, CAUSE = 0x80000002. Write CAUSE → CTRL bit1 = 0.
- Raise src[1] and src[3] together, MASK = 0xFF → intId = 1 first. After ack and EOI, intId = 3 is requested next.
- In REQ for source 0, write MASK = 0 → intReq drops the next negedge, state IDLE, PEND bit0 still 1.
- Two edges on src[4] without service → CTRL bit2 = 1. Write CTRL = 0x5 → bit2 = 0, gie stays 1.
- Assert reset while in SERVICE → intReq = 0, CAUSE = 0, mask = 0. No request until reprogrammed.
